// File: rtl/seq_alu.sv
// Sequential 32-bit ALU: single-cycle logic/arith ops, iterative 1-bit-per-cycle shifts.
// Optional iterative shift-add multiplier on opcode 1010 when SEQ_ALU_MUL_EN is defined.
module seq_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  aluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1010;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  op_r;
  logic [5:0]  cnt;
  logic [31:0] alu_now;
  logic        is_mul;
  logic        multi;
`ifdef SEQ_ALU_MUL_EN
  logic [31:0] mcand, mplier;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign zero      = (result == '0);

  // Result loaded at accept; shifts start from a and mutate result in EXEC.
  always_comb begin
    alu_now = '0;
    is_mul  = 1'b0;
    case (aluop)
      OP_AND:  alu_now = a & b;
      OP_OR:   alu_now = a | b;
      OP_ADD:  alu_now = a + b;
      OP_SUB:  alu_now = a - b;
      OP_SLT:  alu_now = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR:  alu_now = ~(a | b);
      OP_SLL:  alu_now = a;
      OP_SRL:  alu_now = a;
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:  is_mul  = 1'b1;
`endif
      default: alu_now = '0;
    endcase
    multi = is_mul || (((aluop == OP_SLL) || (aluop == OP_SRL)) && (b[4:0] != 5'd0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = multi ? EXEC : DONE;
      EXEC:    if (cnt == 6'd1) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      op_r   <= '0;
      cnt    <= '0;
`ifdef SEQ_ALU_MUL_EN
      mcand  <= '0;
      mplier <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r   <= aluop;
          result <= alu_now;
          cnt    <= is_mul ? 6'd32 : {1'b0, b[4:0]};
`ifdef SEQ_ALU_MUL_EN
          mcand  <= a;
          mplier <= b;
`endif
        end
        EXEC: begin
          cnt <= cnt - 6'd1;
          case (op_r)
            OP_SLL: result <= result << 1;
            OP_SRL: result <= result >> 1;
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
              if (mplier[0]) result <= result + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
`endif
            default: result <= result;
          endcase
        end
        default: result <= result;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: single-cycle ops, shift latency,
// backpressure, undefined opcodes, optional MUL and reset abort.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int vectors = 0;
  int miscompares = 0;

  seq_alu dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Issue one op, scramble inputs after accept, wait for out_valid, then handshake.
  // lat counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       output logic [31:0] res, output logic z, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_valid = 1'b1; aluop = op; a = va; b = vb;
    @(posedge clk); #1;
    in_valid = 1'b0; aluop = 4'b0010; a = 32'hA5A5_A5A5; b = 32'h0000_0003;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    res = result; z = zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; aluop = '0; a = '0; b = '0;
    #13;
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 00000000", result); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got %b want 1", zero); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single;
    logic [3:0]  op [6]  = '{4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0000, 4'b0001};
    logic [31:0] va [6]  = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'h0, 32'hF0F0F0F0, 32'h00FF0000};
    logic [31:0] vb [6]  = '{32'h1, 32'h5, 32'h1, 32'h0, 32'hFF00FF00, 32'h000000FF};
    logic [31:0] exp [6] = '{32'h80000000, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hF000F000, 32'h00FF00FF};
    logic [31:0] res; logic z; int lat;
    for (int i = 0; i < 6; i++) begin
      issue(op[i], va[i], vb[i], res, z, lat);
      vectors++; if (res !== exp[i]) begin miscompares++; $display("FAIL single_result[%0d] got %h want %h", i, res, exp[i]); end
      vectors++; if (z !== (exp[i] == 32'h0)) begin miscompares++; $display("FAIL single_zero[%0d] got %b want %b", i, z, exp[i] == 32'h0); end
      vectors++; if (lat != 1) begin miscompares++; $display("FAIL single_latency[%0d] got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_shift;
    logic [3:0]  op [4]  = '{4'b1000, 4'b1001, 4'b1000, 4'b1001};
    logic [31:0] va [4]  = '{32'h00000001, 32'h80000000, 32'hDEADBEEF, 32'hFFFFFFFF};
    logic [31:0] vb [4]  = '{32'h0000001F, 32'h00000004, 32'h00000000, 32'hFFFFFFE5};
    logic [31:0] exp [4] = '{32'h80000000, 32'h08000000, 32'hDEADBEEF, 32'h07FFFFFF};
    int          el [4]  = '{32, 5, 1, 6};
    logic [31:0] res; logic z; int lat;
    for (int i = 0; i < 4; i++) begin
      issue(op[i], va[i], vb[i], res, z, lat);
      vectors++; if (res !== exp[i]) begin miscompares++; $display("FAIL shift_result[%0d] got %h want %h", i, res, exp[i]); end
      vectors++; if (lat != el[i]) begin miscompares++; $display("FAIL shift_latency[%0d] got %0d want %0d", i, lat, el[i]); end
    end
  endtask

  task automatic test_undef;
    logic [31:0] res; logic z; int lat;
    issue(4'b1111, 32'h12345678, 32'h9ABCDEF0, res, z, lat);
    vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL undef_result got %h want 00000000", res); end
    vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL undef_zero got %b want 1", z); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL undef_latency got %0d want 1", lat); end
  endtask

  task automatic test_mul;
    logic [31:0] res; logic z; int lat;
`ifdef SEQ_ALU_MUL_EN
    issue(4'b1010, 32'h0000FFFF, 32'h00010001, res, z, lat);
    vectors++; if (res !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mul0_result got %h want FFFFFFFF", res); end
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL mul0_latency got %0d want 33", lat); end
    issue(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, res, z, lat);
    vectors++; if (res !== 32'h00000001) begin miscompares++; $display("FAIL mul1_result got %h want 00000001", res); end
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL mul1_latency got %0d want 33", lat); end
`else
    issue(4'b1010, 32'h0000FFFF, 32'h00010001, res, z, lat);
    vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL mul_off_result got %h want 00000000", res); end
    vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL mul_off_zero got %b want 1", z); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL mul_off_latency got %0d want 1", lat); end
`endif
  endtask

  task automatic test_back_to_back;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; aluop = 4'b0000; a = 32'h0000F0F0; b = 32'h0000FF00;
    @(posedge clk); #1;
    aluop = 4'b0010; a = 32'h1; b = 32'h2;
    for (int i = 0; i < 10; i++) begin
      vectors++; if (result !== 32'h0000F000 || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL bp_hold[%0d] got %h/%b want 0000f000/1", i, result, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || result !== 32'h3) begin
      miscompares++; $display("FAIL bp_second got %h/%b want 00000003/1", result, out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_exec;
    int seen;
    in_valid = 1'b1; aluop = 4'b1000; a = 32'h1; b = 32'h1F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL exec_busy got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
    reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
      miscompares++; $display("FAIL exec_reset got %b/%h/%b want 0/00000000/1", out_valid, result, zero); end
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL exec_in_ready got %b want 1", in_ready); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL exec_no_output got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_undef();
    test_mul();
    test_back_to_back();
    test_reset_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The module SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  requester presents a valid operation.
REQ-005 in_ready  output  1  block can accept an operation; equals (state == IDLE).
REQ-006 aluop  input  4  operation code, sampled at accept.
REQ-007 a  input  32  operand A, sampled at accept.
REQ-008 b  input  32  operand B, sampled at accept.
REQ-009 out_valid  output  1  result and zero are valid; equals (state == DONE).
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  32  registered operation result.
REQ-012 zero  output  1  combinational (result == 32'h0).

Function
REQ-013 Accept SHALL occur on a rising edge with in_valid && in_ready; aluop, a and b SHALL be captured into internal registers, with input changes after accept ignored.
REQ-014 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-015 Opcodes: 0000 AND, 0001 OR, 0010 ADD (mod 2^32), 0110 SUB (mod 2^32), 0111 SLT (signed, result 1 or 0), 1100 NOR, 1000 SLL by b[4:0], 1001 SRL by b[4:0] (zero fill).
REQ-016 Logic/arith ops (AND, OR, ADD, SUB, SLT, NOR) SHALL go IDLE->DONE at accept, with result registered at the same edge: out_valid high on the cycle after accept.
REQ-017 Shift ops SHALL go IDLE->EXEC at accept, shift 1 bit per cycle for b[4:0] cycles, then go EXEC->DONE: out_valid high b[4:0]+1 cycles after accept.
REQ-018 A shift with b[4:0]==0 SHALL go IDLE->DONE directly with result = a.
REQ-019 Undefined opcodes SHALL complete as a 1-cycle op with result 32'h0.
REQ-020 In DONE, result SHALL hold stable until out_valid && out_ready, then go DONE->IDLE; a new accept is possible no earlier than the following edge.
REQ-021 in_ready SHALL be low in EXEC and DONE; in_valid there SHALL be ignored and the requester SHALL hold its operation.
REQ-022 out_ready while not in DONE SHALL have no effect.
REQ-023 result SHALL change only at accept, in EXEC, or at reset; zero SHALL track result with no extra latency.

Reset
REQ-024 reset asserted SHALL immediately force state IDLE, out_valid 0, result 32'h0 (so zero = 1), shift counter 0 and operand registers 0.
REQ-025 reset asserted in EXEC or DONE SHALL abort the operation with no result delivered; in_ready SHALL be 1 from the first edge after reset deasserts.

Configuration
REQ-026 Macro SEQ_ALU_MUL_EN: when defined, opcode 1010 SHALL be MUL, the low 32 bits of unsigned a*b via iterative shift-add, 1 bit of b per cycle, in EXEC for exactly 32 cycles (out_valid 33 cycles after accept).
REQ-027 When SEQ_ALU_MUL_EN is undefined, opcode 1010 SHALL behave as an undefined opcode per REQ-019 and no multiplier logic SHALL be synthesized.

Verification
REQ-028 Reset mid-EXEC: accept SLL a=1 b=31, assert reset on cycle 5 -> out_valid 0, result 0, zero 1, in_ready 1 after release, no output produced.
REQ-029 Single-cycle ops: ADD 7FFFFFFF+00000001 -> 80000000 zero 0; SUB 5-5 -> 0 zero 1; SLT FFFFFFFF,00000001 -> 1; NOR 0,0 -> FFFFFFFF; each out_valid exactly 1 cycle after accept.
REQ-030 Shift latency: SLL a=00000001 b=0000001F -> 80000000 with out_valid 32 cycles after accept; SRL a=80000000 b=00000004 -> 08000000 after 5 cycles; SLL b=0 -> a after 1 cycle.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with a new op -> result stable, in_ready 0, second op accepted only after the out handshake.
REQ-032 MUL with SEQ_ALU_MUL_EN: 0000FFFF*00010001 -> FFFFFFFF after 33 cycles; FFFFFFFF*FFFFFFFF -> 00000001; without macro opcode 1010 -> 0, zero 1, 1 cycle.
REQ-033 Undefined opcode 1111 a=12345678 b=9ABCDEF0 -> result 0, zero 1, out_valid 1 cycle after accept.
